// File: rtl/olivia_ctrl_pkg.sv
// Shared types and encodings for the Olivia LEGv8 multi-cycle control sequencer.
package olivia_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StTrap
    } state_e;

    typedef enum logic [2:0] {
        ClsNone,
        ClsRtype,
        ClsLdur,
        ClsStur,
        ClsCbz
    } instr_class_e;

    localparam logic [10:0] OpAdd  = 11'b10001011000;
    localparam logic [10:0] OpSub  = 11'b11001011000;
    localparam logic [10:0] OpAnd  = 11'b10001010000;
    localparam logic [10:0] OpOrr  = 11'b10101010000;
    localparam logic [10:0] OpLdur = 11'b11111000010;
    localparam logic [10:0] OpStur = 11'b11111000000;
    localparam logic [7:0]  OpCbz  = 8'b10110100;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpPassB = 2'b01;
    localparam logic [1:0] AluOpRtype = 2'b10;

endpackage

// File: rtl/olivia_opcode_decoder.sv
// Combinational opcode classifier: instruction[31:21] -> instruction class plus illegal flag.
module olivia_opcode_decoder
    import olivia_ctrl_pkg::*;
(
    input  logic [10:0]  opcode,
    output instr_class_e instr_class,
    output logic         illegal
);

    always_comb begin
        instr_class = ClsNone;
        illegal     = 1'b0;
        // CBZ is identified by its 8-bit prefix; the remaining opcode bits are part of the offset
        if (opcode[10:3] == OpCbz) begin
            instr_class = ClsCbz;
        end else begin
            case (opcode)
                OpAdd, OpSub, OpAnd, OpOrr: instr_class = ClsRtype;
                OpLdur:                     instr_class = ClsLdur;
                OpStur:                     instr_class = ClsStur;
                default:                    illegal     = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/olivia_mc_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the Olivia LEGv8 core, with ready
// handshakes, memory timeout trap and a retired-instruction counter.
module olivia_mc_controller
    import olivia_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RETIRED_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instruction,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic                 alu_zero,
    output logic                 IMEM_REQ,
    output logic                 IR_WRITE,
    output logic                 REG2LOC,
    output logic                 ALU_SRC,
    output logic [1:0]           ALU_OP,
    output logic                 MEM_READ,
    output logic                 MEM_WRITE,
    output logic                 MEM_TO_REG,
    output logic                 REG_WRITE,
    output logic                 PC_WRITE,
    output logic                 PC_SRC,
    output logic                 trap,
    output logic [RETIRED_W-1:0] retired
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT) + 1;

    state_e               state_q, state_d;
    instr_class_e         class_q, class_d;
    logic [WaitW-1:0]     wait_q, wait_d;
    logic [RETIRED_W-1:0] retired_q;
    instr_class_e         dec_class;
    logic                 dec_illegal;
    logic                 timeout;
    logic                 unused_instr_bits;

    assign unused_instr_bits = ^instruction[20:0];

    olivia_opcode_decoder u_decoder (
        .opcode      (instruction[31:21]),
        .instr_class (dec_class),
        .illegal     (dec_illegal)
    );

    // Last waiting cycle: ready here is still accepted, otherwise the request has timed out
    assign timeout = (wait_q == WaitW'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        IMEM_REQ   = 1'b0;
        IR_WRITE   = 1'b0;
        REG2LOC    = 1'b0;
        ALU_SRC    = 1'b0;
        ALU_OP     = AluOpAdd;
        MEM_READ   = 1'b0;
        MEM_WRITE  = 1'b0;
        MEM_TO_REG = 1'b0;
        REG_WRITE  = 1'b0;
        PC_WRITE   = 1'b0;
        PC_SRC     = 1'b0;

        unique case (state_q)
            StFetch: begin
                IMEM_REQ = 1'b1;
                if (imem_ready) begin
                    IR_WRITE = 1'b1;
                    state_d  = StDecode;
                end else if (timeout) begin
                    state_d = StTrap;
                end
            end
            StDecode: begin
                REG2LOC = (dec_class inside {ClsStur, ClsCbz});
                class_d = dec_class;
                state_d = dec_illegal ? StTrap : StExec;
            end
            StExec: begin
                REG2LOC = (class_q inside {ClsStur, ClsCbz});
                ALU_SRC = (class_q inside {ClsLdur, ClsStur});
                case (class_q)
                    ClsRtype: begin
                        ALU_OP  = AluOpRtype;
                        state_d = StWb;
                    end
                    ClsLdur, ClsStur: begin
                        ALU_OP  = AluOpAdd;
                        state_d = StMem;
                    end
                    ClsCbz: begin
                        ALU_OP   = AluOpPassB;
                        PC_WRITE = 1'b1;
                        PC_SRC   = alu_zero;
                        state_d  = StFetch;
                    end
                    default: state_d = StTrap;
                endcase
            end
            StMem: begin
                MEM_READ  = (class_q == ClsLdur);
                MEM_WRITE = (class_q == ClsStur);
                if (dmem_ready) begin
                    if (class_q == ClsStur) begin
                        PC_WRITE = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (timeout) begin
                    state_d = StTrap;
                end
            end
            StWb: begin
                REG_WRITE  = 1'b1;
                MEM_TO_REG = (class_q == ClsLdur);
                PC_WRITE   = 1'b1;
                state_d    = StFetch;
            end
            StTrap: ;
            default: state_d = StTrap;
        endcase

        if (rst) begin
            IMEM_REQ   = 1'b0;
            IR_WRITE   = 1'b0;
            REG2LOC    = 1'b0;
            ALU_SRC    = 1'b0;
            ALU_OP     = AluOpAdd;
            MEM_READ   = 1'b0;
            MEM_WRITE  = 1'b0;
            MEM_TO_REG = 1'b0;
            REG_WRITE  = 1'b0;
            PC_WRITE   = 1'b0;
            PC_SRC     = 1'b0;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (state_q == StFetch || state_q == StMem) begin
            wait_d = wait_q + WaitW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            class_q   <= ClsNone;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            wait_q  <= wait_d;
            if (PC_WRITE) begin
                retired_q <= retired_q + RETIRED_W'(1);
            end
        end
    end

    assign trap    = !rst && (state_q == StTrap);
    assign retired = rst ? '0 : retired_q;

endmodule
